// File: rtl/uart_tx_fifo_if.sv
// Producer-side handshake bundle for uart_tx_fifo: word, valid and ready.
// master: the producer drives i_tx_valid/i_tx_data and observes o_tx_ready.
// slave : the transmitter observes valid/data and drives o_tx_ready.
interface uart_tx_fifo_if #(
  parameter int DATA_W = 8
);
  logic              i_tx_valid;
  logic [DATA_W-1:0] i_tx_data;
  logic              o_tx_ready;

  modport master (
    output i_tx_valid,
    output i_tx_data,
    input  o_tx_ready
  );

  modport slave (
    input  i_tx_valid,
    input  i_tx_data,
    output o_tx_ready
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Purpose     : parametrised UART transmitter (DATA_W bits, optional odd/even
//               parity, 1 or 2 stop bits) fed by a small power-of-2 input FIFO.
// Latency     : a push into an empty FIFO while idle drives the start bit two
//               edges later; queued frames follow each other with no idle gap.
// Backpressure: o_tx_ready is low whenever the FIFO holds FIFO_DEPTH words,
//               even if a word is being popped in the same cycle.
// Ports       : i_clk/i_rst_n clock and async active-low reset; i_enable gates
//               new frame starts only; tx_if carries valid/data/ready;
//               o_tx_serial line (idle high), o_tx_active frame in progress,
//               o_tx_done one-cycle pulse per frame, o_fifo_count words queued.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_enable,
  uart_tx_fifo_if.slave               tx_if,
  output logic                        o_tx_serial,
  output logic                        o_tx_active,
  output logic                        o_tx_done,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CLK_W = $clog2(CLKS_PER_BIT) + 1;
  // Counts data bits (up to 9) and stop bits (up to 2).
  localparam int BIT_W = 4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  // FSM state
  logic [2:0]        state_q,   state_d;
  logic [CLK_W-1:0]  clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q,   shreg_d;
  logic              par_q,     par_d;

  // Registered line outputs
  logic              serial_q,  serial_d;
  logic              active_q,  active_d;
  logic              done_q,    done_d;

  // FIFO state
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q,  wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q,  rd_ptr_d;
  logic [CNT_W-1:0]  count_q,   count_d;

  logic              ready;
  logic              push;
  logic              pop;
  logic              can_start;
  logic              bit_end;
  logic [DATA_W-1:0] head;

  // Ready depends on the stored count only, so a full FIFO never accepts a
  // word on the strength of a same-cycle pop.
  assign ready     = (count_q < CNT_W'(FIFO_DEPTH));
  assign push      = tx_if.i_tx_valid & ready;
  assign can_start = (count_q != '0) & i_enable;
  assign bit_end   = (clk_cnt_q == CLK_W'(CLKS_PER_BIT - 1));
  assign head      = mem_q[rd_ptr_q];

  function automatic logic parity_of(input logic [DATA_W-1:0] d);
    // Odd: total ones including parity is odd; even: total is even.
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    pop       = 1'b0;
    done_d    = 1'b0;

    if (state_q != S_IDLE) begin
      clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (can_start) begin
          pop     = 1'b1;
          shreg_d = head;
          par_d   = parity_of(head);
          state_d = S_START;
        end
      end

      S_START: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = S_DATA;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      S_PAR: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = S_STOP;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          if (bit_cnt_q == BIT_W'(STOP_BITS - 1)) begin
            done_d    = 1'b1;
            bit_cnt_d = '0;
            // Chain straight into the next start bit when more data waits.
            if (can_start) begin
              pop     = 1'b1;
              shreg_d = head;
              par_d   = parity_of(head);
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Line level for the current state; registered, so the pin trails the FSM
  // by one cycle and the pop edge is separated from the start-bit edge.
  always_comb begin
    serial_d = 1'b1;
    case (state_q)
      S_START: serial_d = 1'b0;
      S_DATA:  serial_d = shreg_q[0];
      S_PAR:   serial_d = par_q;
      default: serial_d = 1'b1;
    endcase
  end

  assign active_d = (state_q != S_IDLE);

  // ---------------------------------------------------------------- FIFO
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = tx_if.i_tx_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // Pop only happens with count>0, so this never underflows.
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // ---------------------------------------------------------------- flops
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      serial_q  <= serial_d;
      active_q  <= active_d;
      done_q    <= done_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      mem_q     <= mem_d;
    end
  end

  assign tx_if.o_tx_ready = ready;
  assign o_tx_serial      = serial_q;
  assign o_tx_active      = active_q;
  assign o_tx_done        = done_q;
  assign o_fifo_count     = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four instances cover even parity/1 stop (A),
// odd parity (B), no parity/2 stop (C) and CLKS_PER_BIT=1/DATA_W=5 (D).
// Expected frames are queued at push time; per-instance monitors decode the line.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en  [4];
  logic       vld [4];
  logic [7:0] dat [4];
  logic       rdy [4];
  logic       ser [4];
  logic       act [4];
  logic       dn  [4];
  logic [2:0] cnt [4];

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [15:0] frame;
    logic        b2b;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t q3[$];

  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DATA_W(8)) if_a ();
  uart_tx_fifo_if #(.DATA_W(8)) if_b ();
  uart_tx_fifo_if #(.DATA_W(8)) if_c ();
  uart_tx_fifo_if #(.DATA_W(5)) if_d ();

  assign if_a.i_tx_valid = vld[0];
  assign if_a.i_tx_data  = dat[0];
  assign rdy[0]          = if_a.o_tx_ready;
  assign if_b.i_tx_valid = vld[1];
  assign if_b.i_tx_data  = dat[1];
  assign rdy[1]          = if_b.o_tx_ready;
  assign if_c.i_tx_valid = vld[2];
  assign if_c.i_tx_data  = dat[2];
  assign rdy[2]          = if_c.o_tx_ready;
  assign if_d.i_tx_valid = vld[3];
  assign if_d.i_tx_data  = dat[3][4:0];
  assign rdy[3]          = if_d.o_tx_ready;

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en[0]), .tx_if(if_a.slave),
    .o_tx_serial(ser[0]), .o_tx_active(act[0]), .o_tx_done(dn[0]), .o_fifo_count(cnt[0]));

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en[1]), .tx_if(if_b.slave),
    .o_tx_serial(ser[1]), .o_tx_active(act[1]), .o_tx_done(dn[1]), .o_fifo_count(cnt[1]));

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en[2]), .tx_if(if_c.slave),
    .o_tx_serial(ser[2]), .o_tx_active(act[2]), .o_tx_done(dn[2]), .o_fifo_count(cnt[2]));

  uart_tx_fifo #(.CLKS_PER_BIT(1), .DATA_W(5), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_d (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en[3]), .tx_if(if_d.slave),
    .o_tx_serial(ser[3]), .o_tx_active(act[3]), .o_tx_done(dn[3]), .o_fifo_count(cnt[3]));

  // ------------------------------------------------------------ helpers
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  function automatic int qsize(input int idx);
    case (idx)
      0:       return q0.size();
      1:       return q1.size();
      2:       return q2.size();
      default: return q3.size();
    endcase
  endfunction

  task automatic qpop(input int idx, output exp_t e);
    case (idx)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      2:       e = q2.pop_front();
      default: e = q3.pop_front();
    endcase
  endtask

  // f holds the line bits in time order from bit 0 (start) upwards.
  task automatic expect_frame(input int idx, input logic [15:0] f, input logic b2b);
    exp_t e;
    e.frame = f;
    e.b2b   = b2b;
    case (idx)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      2:       q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  task automatic push(input int idx, input logic [7:0] d);
    int n;
    @(negedge clk);
    dat[idx] = d;
    vld[idx] = 1'b1;
    n = 0;
    while (rdy[idx] !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) timeout($sformatf("push%0d", idx));
    @(posedge clk);
    #1;
    vld[idx] = 1'b0;
  endtask

  task automatic send(input int idx, input logic [7:0] d, input logic [15:0] f, input logic b2b);
    expect_frame(idx, f, b2b);
    push(idx, d);
  endtask

  task automatic wait_drain(input int idx, input int budget);
    int n;
    n = 0;
    while ((qsize(idx) != 0 || act[idx] !== 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) timeout($sformatf("drain%0d", idx));
    repeat (2) @(negedge clk);
  endtask

  // ------------------------------------------------------------ monitor
  task automatic monitor(input int idx);
    int          len, cpb, gap, dones;
    logic [15:0] got;
    logic        glitch, aborted;
    exp_t        e;
    len = (idx == 3) ? 7 : 11;
    cpb = (idx == 3) ? 1 : 4;
    gap = 0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1 || act[idx] !== 1'b1) begin
        gap++;
        continue;
      end
      got = '0; glitch = 1'b0; aborted = 1'b0; dones = 0;
      for (int s = 0; s < len * cpb; s++) begin
        if (s != 0) @(negedge clk);
        if (rst_n !== 1'b1) aborted = 1'b1;
        if (s % cpb == 0) got[s / cpb] = ser[idx];
        else if (ser[idx] !== got[s / cpb]) glitch = 1'b1;
        if (act[idx] !== 1'b1) glitch = 1'b1;
        if (dn[idx] === 1'b1) dones++;
      end
      if (aborted) begin
        gap = 0;
        continue;
      end
      if (qsize(idx) == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL mon%0d_unexpected: got frame 0x%0h, want no frame", idx, got);
      end else begin
        qpop(idx, e);
        check($sformatf("mon%0d_frame", idx), 32'(got), 32'(e.frame));
        check($sformatf("mon%0d_bit_stable", idx), 32'(glitch), 32'd0);
        check($sformatf("mon%0d_done_pulses", idx), 32'(dones), 32'd1);
        if (e.b2b) check($sformatf("mon%0d_idle_gap", idx), 32'(gap), 32'd0);
      end
      gap = 0;
    end
  endtask

  initial monitor(0);
  initial monitor(1);
  initial monitor(2);
  initial monitor(3);

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------ stimulus
  logic t3_par [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    int   n, acc;
    logic r;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      en[i] = 1'b1; vld[i] = 1'b0; dat[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    check("rst_serial", 32'(ser[0]), 32'd1);
    check("rst_active", 32'(act[0]), 32'd0);
    check("rst_done",   32'(dn[0]),  32'd0);
    check("rst_count",  32'(cnt[0]), 32'd0);
    check("rst_ready",  32'(rdy[0]), 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: 0xA5 even parity -> 0,1,0,1,0,0,1,0,1,0,1 and start bit at N+2
    expect_frame(0, {5'd0, 1'b1, 1'b0, 8'hA5, 1'b0}, 1'b0);
    @(negedge clk);
    vld[0] = 1'b1;
    dat[0] = 8'hA5;
    check("t1_ready", 32'(rdy[0]), 32'd1);
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    @(negedge clk);
    check("t1_serial_n0", 32'(ser[0]), 32'd1);
    check("t1_count_n0",  32'(cnt[0]), 32'd1);
    @(negedge clk);
    check("t1_serial_n1", 32'(ser[0]), 32'd1);
    check("t1_count_n1",  32'(cnt[0]), 32'd0);
    @(negedge clk);
    check("t1_serial_n2", 32'(ser[0]), 32'd0);
    check("t1_active_n2", 32'(act[0]), 32'd1);
    wait_drain(0, 200);

    // 2: odd parity 0x07 -> p=0, 0x00 -> p=1; no parity, 2 stop, 0xFF
    send(1, 8'h07, {5'd0, 1'b1, 1'b0, 8'h07, 1'b0}, 1'b0);
    send(1, 8'h00, {5'd0, 1'b1, 1'b1, 8'h00, 1'b0}, 1'b1);
    send(2, 8'hFF, {5'd0, 2'b11, 8'hFF, 1'b0}, 1'b0);
    wait_drain(1, 300);
    wait_drain(2, 300);

    // 6: CLKS_PER_BIT=1, DATA_W=5, 0x15 -> 0,1,0,1,0,1,1
    send(3, 8'h15, {9'd0, 1'b1, 5'h15, 1'b0}, 1'b0);
    wait_drain(3, 100);

    // 3: hold valid with 0x11.. -> 5 accepted, back-to-back, order kept
    @(negedge clk);
    vld[0] = 1'b1;
    dat[0] = 8'h11;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      r = rdy[0];
      if (r) begin
        expect_frame(0, {5'd0, 1'b1, (acc < 6) ? t3_par[acc] : 1'b0, dat[0], 1'b0}, (acc != 0));
        acc++;
      end
      @(posedge clk);
      #1;
      if (r) dat[0] = dat[0] + 8'd1;
      @(negedge clk);
    end
    check("t3_accepted", 32'(acc), 32'd5);
    check("t3_ready_full", 32'(rdy[0]), 32'd0);
    check("t3_count_full", 32'(cnt[0]), 32'd4);
    vld[0] = 1'b0;
    wait_drain(0, 400);

    // 4: enable gating
    en[0] = 1'b0;
    send(0, 8'h3C, {5'd0, 1'b1, 1'b0, 8'h3C, 1'b0}, 1'b0);
    send(0, 8'hC3, {5'd0, 1'b1, 1'b0, 8'hC3, 1'b0}, 1'b0);
    repeat (10) @(negedge clk);
    check("t4_hold_serial", 32'(ser[0]), 32'd1);
    check("t4_hold_active", 32'(act[0]), 32'd0);
    check("t4_hold_count",  32'(cnt[0]), 32'd2);
    en[0] = 1'b1;
    n = 0;
    while (act[0] !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    if (n >= 10) timeout("t4_start");
    repeat (8) @(negedge clk);
    en[0] = 1'b0;
    n = 0;
    while (act[0] !== 1'b0 && n < 80) begin @(negedge clk); n++; end
    if (n >= 80) timeout("t4_finish");
    repeat (20) @(negedge clk);
    check("t4_gated_active", 32'(act[0]), 32'd0);
    check("t4_gated_serial", 32'(ser[0]), 32'd1);
    check("t4_gated_count",  32'(cnt[0]), 32'd1);
    check("t4_frames_left",  32'(qsize(0)), 32'd1);
    en[0] = 1'b1;
    wait_drain(0, 200);

    // 5: reset during DATA aborts the frame at once
    push(0, 8'h5A);
    n = 0;
    while (act[0] !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    if (n >= 10) timeout("t5_start");
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_rst_serial", 32'(ser[0]), 32'd1);
    check("t5_rst_active", 32'(act[0]), 32'd0);
    check("t5_rst_count",  32'(cnt[0]), 32'd0);
    check("t5_rst_ready",  32'(rdy[0]), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("t5_post_serial", 32'(ser[0]), 32'd1);
    check("t5_post_active", 32'(act[0]), 32'd0);
    check("t5_post_count",  32'(cnt[0]), 32'd0);

    for (int i = 0; i < 4; i++) begin
      check($sformatf("end_queue%0d", i), 32'(qsize(i)), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
